// File: rtl/md_unit_pkg.sv
// md_defs: shared definitions for the multiply/divide unit.
//   md_op_e    - 3-bit operation codes driven on md_unit.i_op
//   md_state_e - FSM state encodings (IDLE / MUL / DIV)
//   RES_W      - width of the combined {hi, lo} result
//   is_multicycle() - which ops occupy the unit for more than one cycle
// Build option: MDU_MADD_EN makes MADD/MADDU multi-cycle accumulate ops;
// without it those codes are no-ops.
package md_defs;

    localparam int RES_W = 64;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    function automatic logic is_multicycle(input md_op_e op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/md_unit_div_core.sv
// md_div_core: unsigned restoring divider on operand magnitudes.
//   i_dividend, i_divisor  - unsigned 32-bit operands
//   o_quotient, o_remainder - unsigned results
// Purely combinational; the caller holds operands stable for the whole
// busy window and applies any sign fix-up. Divisor 0 gives garbage that
// the caller discards.
module md_div_core (
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [32:0] w_rem;

    always_comb begin
        w_rem      = '0;
        o_quotient = '0;
        for (int i = 31; i >= 0; i--) begin
            w_rem = {w_rem[31:0], i_dividend[i]};
            if (w_rem >= {1'b0, i_divisor}) begin
                w_rem         = w_rem - {1'b0, i_divisor};
                o_quotient[i] = 1'b1;
            end
        end
        o_remainder = w_rem[31:0];
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO.
//   i_clk, i_reset (async, active low)
//   i_start/i_op/i_a/i_b - MD instruction in E with forwarded operands
//   i_md_use_d           - D-stage instruction touches HI/LO
//   i_rd_sel             - 0 reads LO, 1 reads HI on o_rd
//   o_busy, o_stall_req  - multi-cycle in progress / freeze request to hazard unit
//   o_hi, o_lo, o_rd     - architectural registers and MFHI/MFLO read port
// Build option: MDU_MADD_EN enables MADD/MADDU accumulate.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_md_use_d,
    input  logic        i_rd_sel,
    output logic        o_busy,
    output logic        o_stall_req,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [31:0] o_rd
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   r_state;
    md_op_e      r_op;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic        r_busy;

    md_op_e      w_op;
    logic        w_start_mc;
    assign w_op       = md_op_e'(i_op);
    assign w_start_mc = i_start && is_multicycle(w_op);

    // Multiplier: extend both operands to 64 bits so one unsigned multiply
    // covers the signed and unsigned forms (low 64 bits are exact).
    logic             w_mul_signed;
    logic [RES_W-1:0] w_ext_a, w_ext_b, w_prod, w_mul_res;
    assign w_mul_signed = (r_op == OP_MULT) || (r_op == OP_MADD);
    assign w_ext_a = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_ext_a * w_ext_b;
`ifdef MDU_MADD_EN
    assign w_mul_res = ((r_op == OP_MADD) || (r_op == OP_MADDU)) ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
    assign w_mul_res = w_prod;
`endif

    // Divider: divide magnitudes, then restore signs. Quotient truncates
    // toward zero; remainder takes the dividend's sign. 0x80000000 negates
    // to itself, which is the correct unsigned magnitude 2^31.
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_dvd, w_dvs, w_q_mag, w_r_mag, w_quo, w_rem;
    assign w_neg_a = (r_op == OP_DIV) && r_a[31];
    assign w_neg_b = (r_op == OP_DIV) && r_b[31];
    assign w_dvd   = w_neg_a ? -r_a : r_a;
    assign w_dvs   = w_neg_b ? -r_b : r_b;

    md_div_core u_div (
        .i_dividend (w_dvd),
        .i_divisor  (w_dvs),
        .o_quotient (w_q_mag),
        .o_remainder(w_r_mag)
    );

    assign w_quo = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
    assign w_rem = w_neg_a ? -w_r_mag : w_r_mag;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULT;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_mc) begin
                        r_a    <= i_a;
                        r_b    <= i_b;
                        r_op   <= w_op;
                        r_busy <= 1'b1;
                        if ((w_op == OP_DIV) || (w_op == OP_DIVU)) begin
                            r_state <= ST_DIV;
                            r_cnt   <= CW'(DIV_CYCLES);
                        end else begin
                            r_state <= ST_MUL;
                            r_cnt   <= CW'(MULT_CYCLES);
                        end
                    end else if (i_start && (w_op == OP_MTHI)) begin
                        r_hi <= i_a;
                    end else if (i_start && (w_op == OP_MTLO)) begin
                        r_lo <= i_a;
                    end
                end
                ST_MUL, ST_DIV: begin
                    // Operands stay latched, so the result is valid by the last cycle.
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (r_state == ST_MUL) begin
                            {r_hi, r_lo} <= w_mul_res;
                        end else if (r_b != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_stall_req = i_md_use_d && (r_busy || w_start_mc);
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_rd        = i_rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (default parameters: 5 mult / 10 div cycles).
module tb_md_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        md_use_d = 1'b0;
    logic        rd_sel = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo, rd;

    always #5 clk = ~clk;

    md_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_md_use_d(md_use_d), .i_rd_sel(rd_sel),
        .o_busy(busy), .o_stall_req(stall), .o_hi(hi), .o_lo(lo), .o_rd(rd)
    );

    // The hazard unit never issues an MD op while the unit is busy.
    always @(posedge clk) begin
        if (rst_n && busy && start) $error("start issued while busy");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles, bounded so a stuck unit still reaches the summary.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo;
        int          cyc;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] ph, input logic [31:0] pl,
                                input int c, input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.name = nm; v.op = o; v.a = x; v.b = y; v.pre_hi = ph; v.pre_lo = pl;
        v.cyc = c; v.exp_hi = eh; v.exp_lo = el;
        return v;
    endfunction

    initial begin
        int c;

        vecs.push_back(mk("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        0, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA));
        vecs.push_back(mk("mult_max",  OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 5, 32'h3FFFFFFF, 32'h00000001));
        vecs.push_back(mk("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 5, 32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk("divu",      OP_DIVU,  32'd100,      32'd7,        0, 0, 10, 32'd2,       32'd14));
        vecs.push_back(mk("div_negn",  OP_DIV,   32'hFFFFFFF9, 32'd2,        0, 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk("div_negd",  OP_DIV,   32'd7,        32'hFFFFFFFE, 0, 0, 10, 32'd1,       32'hFFFFFFFD));
        vecs.push_back(mk("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 10, 32'd0,       32'h80000000));
        vecs.push_back(mk("divu_big",  OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 0, 0, 10, 32'h80000000, 32'd0));
        vecs.push_back(mk("div_zero",  OP_DIV,   32'd123,      32'd0,  32'h11, 32'h22, 10, 32'h11, 32'h22));
        vecs.push_back(mk("divu_zero", OP_DIVU,  32'hFFFFFFFF, 32'd0,  32'h5,  32'h6,  10, 32'h5,  32'h6));
        vecs.push_back(mk("mthi",      OP_MTHI,  32'hDEADBEEF, 32'd9,  32'h1,  32'h2,  0, 32'hDEADBEEF, 32'h2));
        vecs.push_back(mk("mtlo",      OP_MTLO,  32'hCAFEF00D, 32'd9,  32'h3,  32'h4,  0, 32'h3, 32'hCAFEF00D));
`ifdef MDU_MADD_EN
        vecs.push_back(mk("maddu",     OP_MADDU, 32'd1, 32'd1,        32'h1, 32'hFFFFFFFF, 5, 32'h2, 32'h0));
        vecs.push_back(mk("madd",      OP_MADD,  32'hFFFFFFFF, 32'd3, 32'h0, 32'h5,        5, 32'h0, 32'h2));
`else
        vecs.push_back(mk("maddu_nop", OP_MADDU, 32'd1, 32'd1,        32'h1, 32'hFFFFFFFF, 0, 32'h1, 32'hFFFFFFFF));
        vecs.push_back(mk("madd_nop",  OP_MADD,  32'hFFFFFFFF, 32'd3, 32'h0, 32'h5,        0, 32'h0, 32'h5));
`endif

        // Reset state; stall_req is combinational even under reset.
        md_use_d = 1'b1; start = 1'b1; op = OP_DIV;
        #2;
        chk("rst_stall_start", 32'(stall), 32'd1);
        start = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(stall), 32'd0);
        md_use_d = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_rd_lo", rd, 32'd0);
        rd_sel = 1'b1;
        #1;
        chk("rst_rd_hi", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            issue(OP_MTHI, vecs[i].pre_hi, 32'd0);
            issue(OP_MTLO, vecs[i].pre_lo, 32'd0);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(c);
            chk({vecs[i].name, "_cyc"}, 32'(c), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            rd_sel = 1'b1; #1;
            chk({vecs[i].name, "_rdhi"}, rd, vecs[i].exp_hi);
            rd_sel = 1'b0; #1;
            chk({vecs[i].name, "_rdlo"}, rd, vecs[i].exp_lo);
        end

        // MFLO waiting in D behind a MULT: start cycle + 5 busy cycles of stall.
        md_use_d = 1'b1;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
        #1;
        chk("stall_start", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (stall && c < 200) begin
            c++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(c), 32'd5);
        chk("stall_busy_low", 32'(busy), 32'd0);
        rd_sel = 1'b0; #1;
        chk("stall_mflo", rd, 32'd42);
        md_use_d = 1'b0;

        // No D-stage user: busy without stall.
        issue(OP_DIVU, 32'd9, 32'd3);
        chk("nouse_busy", 32'(busy), 32'd1);
        chk("nouse_stall", 32'(stall), 32'd0);
        wait_idle(c);
        chk("nouse_lo", lo, 32'd3);

        // Reset in the 3rd busy cycle of a DIV aborts and clears everything.
        issue(OP_MTHI, 32'h55, 32'd0);
        issue(OP_MTLO, 32'h66, 32'd0);
        issue(OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        issue(OP_MULT, 32'd3, 32'd4);
        wait_idle(c);
        chk("post_rst_cyc", 32'(c), 32'd5);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
